// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: combinational extension at the input, then a
// two-entry skid buffer (main M drives the outputs, skid K absorbs the word
// accepted in the first stalled cycle) so back-pressure never drops a result.
//
// state | meaning
// EMPTY | M and K invalid, ready for input
// ONE   | M valid and presented, K free
// TWO   | M and K valid, input stalled
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       immSrc,
   input  logic [31:0]      instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  immOut,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err
);

   localparam int EW = XLEN + TAG_W + 1;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] imm_ext;
   logic            err_ext;
   logic [EW-1:0]   in_ent;
   logic [EW-1:0]   m_q, m_d;
   logic [EW-1:0]   k_q, k_d;

   // Opcode bits are never decoded; the name keeps them out of unused-signal lint.
   logic            unused_instr_lo;
   assign unused_instr_lo = ^instr[6:0];

   // Immediate formation: prefill with the sign (or zero), then place the field.
   always_comb begin
      imm_ext = {XLEN{instr[31]}};
      err_ext = 1'b0;
      case (immSrc)
         3'b000: imm_ext[11:0] = instr[31:20];
         3'b001: imm_ext[11:0] = {instr[31:25], instr[11:7]};
         3'b010: imm_ext[20:0] = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         3'b011: imm_ext[12:0] = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         3'b100: imm_ext[31:0] = {instr[31:12], 12'b0};
         3'b101: begin
            imm_ext      = '0;
            imm_ext[4:0] = instr[19:15];
         end
         3'b110: begin
            imm_ext = '0;
            if (XLEN == 64) begin
               imm_ext[5:0] = instr[25:20];
            end else begin
               imm_ext[4:0] = instr[24:20];
            end
         end
         default: begin
            imm_ext = '0;
            err_ext = 1'b1;
         end
      endcase
   end

   assign in_ent = {imm_ext, in_tag, err_ext};

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state; acceptance is implied by state so in_ready never loops back.
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (in_valid) state_d = ONE;
         ONE: begin
            if (in_valid && !out_ready) begin
               state_d = TWO;
            end else if (!in_valid && out_ready) begin
               state_d = EMPTY;
            end
         end
         TWO:     if (out_ready) state_d = ONE;
         default: state_d = EMPTY;
      endcase
   end

   // Handshake outputs and buffer next values.
   always_comb begin
      in_ready  = (state_q != TWO);
      out_valid = (state_q != EMPTY);
      m_d       = m_q;
      k_d       = k_q;
      case (state_q)
         EMPTY: if (in_valid) m_d = in_ent;
         ONE: begin
            if (in_valid && out_ready) begin
               m_d = in_ent;
            end else if (in_valid) begin
               k_d = in_ent;
            end
         end
         TWO:     if (out_ready) m_d = k_q;
         default: ;
      endcase
   end

   // Buffer registers; reset discards everything held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q <= '0;
         k_q <= '0;
      end else begin
         m_q <= m_d;
         k_q <= k_d;
      end
   end

   assign {immOut, out_tag, out_err} = m_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus and
// are checked each cycle against a queue model of a two-deep FIFO.
module tb_imm_gen_pipe;
   localparam int TAG_W = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   logic [2:0]       immSrc = '0;
   logic [31:0]      instr = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_ready = 1'b0;

   logic             in_ready32, out_valid32, err32;
   logic [31:0]      imm32;
   logic [TAG_W-1:0] tag32;
   logic             in_ready64, out_valid64, err64;
   logic [63:0]      imm64;
   logic [TAG_W-1:0] tag64;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) u32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
      .immSrc(immSrc), .instr(instr), .in_tag(in_tag),
      .out_valid(out_valid32), .out_ready(out_ready),
      .immOut(imm32), .out_tag(tag32), .out_err(err32));

   imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) u64 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
      .immSrc(immSrc), .instr(instr), .in_tag(in_tag),
      .out_valid(out_valid64), .out_ready(out_ready),
      .immOut(imm64), .out_tag(tag64), .out_err(err64));

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      logic [63:0]      i64;
      logic [31:0]      i32;
      logic [TAG_W-1:0] tag;
      logic             err;
   } ent_t;

   ent_t             mq[$];
   logic [TAG_W-1:0] dut_log[$];

   function automatic logic [63:0] ref_imm(input logic [2:0] src, input logic [31:0] ins,
                                           input bit x64);
      logic [63:0] v;
      case (src)
         3'd0: v = 64'($signed(ins[31:20]));
         3'd1: v = 64'($signed({ins[31:25], ins[11:7]}));
         3'd2: v = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
         3'd3: v = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
         3'd4: v = 64'($signed({ins[31:12], 12'b0}));
         3'd5: v = 64'(ins[19:15]);
         3'd6: v = x64 ? 64'(ins[25:20]) : 64'(ins[24:20]);
         default: v = '0;
      endcase
      return v;
   endfunction

   // Reference: a FIFO of capacity two, pop then push on each clock edge.
   bit          m_a, m_d;
   ent_t        m_e;
   logic [63:0] m_t;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
      end else begin
         m_a = in_valid && (mq.size() < 2);
         m_d = out_ready && (mq.size() > 0);
         if (m_d) void'(mq.pop_front());
         if (m_a) begin
            m_e.i64 = ref_imm(immSrc, instr, 1'b1);
            m_t     = ref_imm(immSrc, instr, 1'b0);
            m_e.i32 = m_t[31:0];
            m_e.tag = in_tag;
            m_e.err = (immSrc == 3'd7);
            mq.push_back(m_e);
         end
      end
   end

   // Per-cycle compare on the falling edge; also logs every DUT dequeue.
   bit               c_ok, e_v, e_r, e_err;
   logic [31:0]      e_i32;
   logic [63:0]      e_i64;
   logic [TAG_W-1:0] e_tag;
   always @(negedge clk) begin
      if (!rst) begin
         e_v   = (mq.size() > 0);
         e_r   = (mq.size() < 2);
         e_i32 = '0; e_i64 = '0; e_tag = '0; e_err = 1'b0;
         if (e_v) begin
            e_i32 = mq[0].i32; e_i64 = mq[0].i64; e_tag = mq[0].tag; e_err = mq[0].err;
         end
         tests_run++;
         c_ok = (out_valid32 === e_v) && (out_valid64 === e_v) &&
                (in_ready32 === e_r) && (in_ready64 === e_r);
         if (e_v) begin
            c_ok = c_ok && (imm32 === e_i32) && (imm64 === e_i64) &&
                   (tag32 === e_tag) && (tag64 === e_tag) &&
                   (err32 === e_err) && (err64 === e_err);
         end
         if (!c_ok) begin
            tests_failed++;
            $display("FAIL cycle_check t=%0t got v=%b/%b r=%b/%b imm=%h/%h tag=%0d/%0d err=%b/%b want v=%b r=%b imm=%h/%h tag=%0d err=%b",
                     $time, out_valid32, out_valid64, in_ready32, in_ready64, imm32, imm64,
                     tag32, tag64, err32, err64, e_v, e_r, e_i32, e_i64, e_tag, e_err);
         end
         if (out_valid32 && out_ready) dut_log.push_back(tag32);
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] s, input logic [31:0] i,
                        input logic [TAG_W-1:0] t, input logic r, output bit acc);
      in_valid  = v;
      immSrc    = s;
      instr     = i;
      in_tag    = t;
      out_ready = r;
      acc       = v && in_ready32;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit a;
      int nt;
      int cyc;
      int accepted;
      int cnt;

      #1 rst = 1'b1;
      #2;
      chk("rst_valid", 64'(out_valid32), 64'd0);
      chk("rst_ready", 64'(in_ready32), 64'd1);
      chk("rst_imm",   imm64, 64'd0);
      chk("rst_tag",   64'(tag32), 64'd0);
      chk("rst_err",   64'(err32), 64'd0);
      #9 rst = 1'b0;
      @(posedge clk);
      #1;

      drive(1'b1, 3'd0, 32'hFFF00093, 5'd1, 1'b1, a);
      chk("i_32", 64'(imm32), 64'hFFFF_FFFF);
      chk("i_64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
      drive(1'b1, 3'd1, 32'hFE112E23, 5'd2, 1'b1, a);
      chk("s_32", 64'(imm32), 64'hFFFF_FFFC);
      chk("s_err", 64'(err32), 64'd0);
      drive(1'b1, 3'd4, 32'h800000B7, 5'd3, 1'b1, a);
      chk("u_64", imm64, 64'hFFFF_FFFF_8000_0000);
      chk("u_32", 64'(imm32), 64'h8000_0000);
      drive(1'b1, 3'd5, 32'h000FD073, 5'd4, 1'b1, a);
      chk("z_64", imm64, 64'h1F);
      drive(1'b1, 3'd6, 32'h03F0D093, 5'd5, 1'b1, a);
      chk("sh_64", imm64, 64'h3F);
      chk("sh_32", 64'(imm32), 64'h1F);
      drive(1'b1, 3'd2, 32'h800000EF, 5'd6, 1'b1, a);
      chk("j_32", 64'(imm32), 64'hFFF0_0000);
      drive(1'b1, 3'd3, 32'h80000063, 5'd8, 1'b1, a);
      chk("b_32", 64'(imm32), 64'hFFFF_F000);

      dut_log.delete();
      drive(1'b1, 3'd7, 32'hFFFFFFFF, 5'd7, 1'b1, a);
      chk("rsv_imm", imm64, 64'd0);
      chk("rsv_err", 64'(err64), 64'd1);
      chk("rsv_tag", 64'(tag32), 64'd7);
      for (int k = 0; k < 3; k++) drive(1'b0, 3'd0, 32'h0, 5'd0, 1'b1, a);
      cnt = 0;
      foreach (dut_log[k]) if (dut_log[k] == 5'd7) cnt++;
      chk("rsv_once", 64'(cnt), 64'd1);
      chk("rsv_drained", 64'(out_valid32), 64'd0);

      dut_log.delete();
      nt = 1;
      for (int c = 1; c <= 16; c++) begin
         drive(nt <= 6, 3'd0, (32'(nt) << 20) | 32'h93, TAG_W'(nt),
               !(c >= 2 && c <= 5), a);
         if (a) nt++;
         if (c >= 2 && c <= 5) begin
            chk("bp_ready_low", 64'(in_ready32), 64'd0);
            chk("bp_hold_tag",  64'(tag32), 64'd1);
            chk("bp_hold_imm",  64'(imm32), 64'd1);
         end
      end
      for (int k = 0; k < 3; k++) drive(1'b0, 3'd0, 32'h0, 5'd0, 1'b1, a);
      chk("bp_accepted", 64'(nt), 64'd7);
      chk("bp_count", 64'(dut_log.size()), 64'd6);
      for (int k = 0; k < 6; k++) begin
         if (k < dut_log.size()) chk("bp_order", 64'(dut_log[k]), 64'(k + 1));
      end

      dut_log.delete();
      drive(1'b1, 3'd0, 32'h00A00093, 5'd10, 1'b0, a);
      drive(1'b1, 3'd0, 32'h00B00093, 5'd11, 1'b0, a);
      chk("two_ready", 64'(in_ready32), 64'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("mrst_valid", 64'(out_valid32), 64'd0);
      chk("mrst_valid64", 64'(out_valid64), 64'd0);
      chk("mrst_ready", 64'(in_ready32), 64'd1);
      chk("mrst_tag", 64'(tag32), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) drive(1'b0, 3'd0, 32'h0, 5'd0, 1'b1, a);
      drive(1'b1, 3'd0, 32'h00C00093, 5'd12, 1'b1, a);
      for (int k = 0; k < 3; k++) drive(1'b0, 3'd0, 32'h0, 5'd0, 1'b1, a);
      chk("mrst_count", 64'(dut_log.size()), 64'd1);
      if (dut_log.size() > 0) chk("mrst_tag_out", 64'(dut_log[0]), 64'd12);

      accepted = 0;
      cyc      = 0;
      while (accepted < 10000 && cyc < 60000) begin
         drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom,
               TAG_W'($urandom_range(0, 31)), $urandom_range(0, 3) != 0, a);
         if (a) accepted++;
         cyc++;
      end
      chk("rand_budget", 64'(accepted), 64'd10000);
      for (int k = 0; k < 4; k++) drive(1'b0, 3'd0, 32'h0, 5'd0, 1'b1, a);
      chk("rand_drained", 64'(out_valid32), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
